fft_input_loader: RTL and testbench
===================================

// Module: fft_input_loader
// PURPOSE
//  Serial-to-parallel writer feeding the 32-point FFT Stage1 real inputs i_a0..i_a31.
//  Accepts one real sample per valid/ready beat and assembles 32-sample frames in two
//  ping-pong banks. Presents each complete frame in parallel, with a valid/ack handshake,
//  while the next frame fills.
// PARAMETERS
//  p_inputBits  9  signed sample width; equals the Stage1 p_inputBits
//  p_points     32 frame length; fixed at 32, other values unsupported
//  p_cntBits    8  width of o_frame_cnt
// PORTS
//  CLK            in   1               single clock, rising edge
//  RST            in   1               async, active-high reset
//  i_sample       in   p_inputBits     incoming real sample, two's complement
//  i_valid        in   1               i_sample valid this cycle
//  o_ready        out  1               loader can accept a sample this cycle
//  i_flush        in   1               sync: drop partial frame, empty both banks
//  o_a0..o_a31    out  p_inputBits ea  parallel frame to Stage1 i_a0..i_a31
//  o_frame_valid  out  1               o_a* hold a complete frame
//  i_frame_ack    in   1               consumer has taken the presented frame
//  o_frame_cnt    out  p_cntBits       frames consumed, modulo 2^p_cntBits
// BEHAVIOUR
//  - State: banks buf0/buf1 (32 x p_inputBits), wr_sel, rd_sel, full[1:0], wr_cnt[4:0].
//  - Reset (async): all outputs, banks, full, wr_sel, rd_sel, wr_cnt and o_frame_cnt = 0.
//    o_ready = 1 after reset. A reset mid-frame discards all data.
//  - o_ready = ~full[wr_sel] (combinational from registers).
//  - Accept = i_valid & o_ready. On accept, write buf[wr_sel][idx(wr_cnt)] and add 1 to wr_cnt.
//  - On accept with wr_cnt==31: full[wr_sel]<=1, wr_sel toggles, wr_cnt wraps to 0.
//  - o_frame_valid = full[rd_sel], registered. If rd_sel is the bank just filled,
//    o_frame_valid rises on the cycle after the 32nd accept.
//  - o_aK = buf[rd_sel][K], registered. Values are stable for as long as o_frame_valid=1.
//    When o_frame_valid=0, o_aK is don't-care.
//  - Consume = o_frame_valid & i_frame_ack: full[rd_sel]<=0, rd_sel toggles,
//    o_frame_cnt += 1 (wraps 2^p_cntBits-1 -> 0). i_frame_ack is ignored when not valid.
//  - Consume and 32nd-accept in the same cycle touch different banks and both take effect.
//    Back-to-back frames then stream with no bubble.
//  - Both banks full: o_ready=0 and i_valid is ignored (no loss; the upstream holds the sample).
//  - If the consumer acks every frame, throughput is 1 sample/cycle and latency is
//    1 cycle from the last sample to o_frame_valid.
//  - i_flush (highest priority over accept/consume): wr_cnt=0, full=0, wr_sel=rd_sel=0,
//    o_frame_valid=0 next cycle. Bank contents and o_frame_cnt are kept.
//  - Samples are stored unmodified; sign extension and imag-part padding happen in Stage1.
// CONFIGURATION
//  FFT_LOADER_BITREV_EN defined: idx(n) = 5-bit bit-reverse of n, so the sample with time
//    index n appears on o_a[bitrev(n)]. Use this when Stage1 expects bit-reversed input order.
//  Not defined: idx(n) = n (natural order). The consumer must reorder.
//  Handshake and timing are identical in both builds.
// TESTING
//  1 Reset: RST=1 mid-frame after 10 samples -> o_ready=1, o_frame_valid=0, cnt=0;
//    the next 32 samples form a fresh frame.
//  2 Natural order: feed 0..31 continuously, ack held 0 -> o_frame_valid=1 the cycle after
//    sample 31, o_aK=K; a second frame fills and then o_ready=0.
//  3 BITREV_EN: feed 0..31 -> o_a1=16, o_a2=8, o_a3=24, o_a31=31, o_a0=0.
//  4 Streaming: 4 frames back-to-back, i_frame_ack=1 -> o_ready never drops,
//    o_frame_valid asserts on 4 frames, o_frame_cnt=4.
//  5 Backpressure: both banks full, i_valid=1 with sample 0x1FF for 5 cycles -> no accepts;
//    after one ack, 0x1FF is written to slot 0 of the freed bank.
//  6 Flush at wr_cnt=17 with one frame presented -> o_frame_valid=0 next cycle; the next
//    32 samples form a frame; o_frame_cnt is unchanged. Negative samples (-256) pass unchanged.

Source files
------------

// File: rtl/fft_input_loader.sv
// Serial-to-parallel ping-pong frame loader feeding the 32-point FFT Stage1 real inputs.
// Define FFT_LOADER_BITREV_EN to store samples in bit-reversed slot order.
module fft_input_loader #(
    parameter int p_inputBits = 9,
    parameter int p_points    = 32,
    parameter int p_cntBits   = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [p_inputBits-1:0] i_sample,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_flush,
    output logic [p_inputBits-1:0] o_a0,
    output logic [p_inputBits-1:0] o_a1,
    output logic [p_inputBits-1:0] o_a2,
    output logic [p_inputBits-1:0] o_a3,
    output logic [p_inputBits-1:0] o_a4,
    output logic [p_inputBits-1:0] o_a5,
    output logic [p_inputBits-1:0] o_a6,
    output logic [p_inputBits-1:0] o_a7,
    output logic [p_inputBits-1:0] o_a8,
    output logic [p_inputBits-1:0] o_a9,
    output logic [p_inputBits-1:0] o_a10,
    output logic [p_inputBits-1:0] o_a11,
    output logic [p_inputBits-1:0] o_a12,
    output logic [p_inputBits-1:0] o_a13,
    output logic [p_inputBits-1:0] o_a14,
    output logic [p_inputBits-1:0] o_a15,
    output logic [p_inputBits-1:0] o_a16,
    output logic [p_inputBits-1:0] o_a17,
    output logic [p_inputBits-1:0] o_a18,
    output logic [p_inputBits-1:0] o_a19,
    output logic [p_inputBits-1:0] o_a20,
    output logic [p_inputBits-1:0] o_a21,
    output logic [p_inputBits-1:0] o_a22,
    output logic [p_inputBits-1:0] o_a23,
    output logic [p_inputBits-1:0] o_a24,
    output logic [p_inputBits-1:0] o_a25,
    output logic [p_inputBits-1:0] o_a26,
    output logic [p_inputBits-1:0] o_a27,
    output logic [p_inputBits-1:0] o_a28,
    output logic [p_inputBits-1:0] o_a29,
    output logic [p_inputBits-1:0] o_a30,
    output logic [p_inputBits-1:0] o_a31,
    output logic                   o_frame_valid,
    input  logic                   i_frame_ack,
    output logic [p_cntBits-1:0]   o_frame_cnt
);

    typedef logic [p_inputBits-1:0] sample_t;

    localparam logic [p_cntBits-1:0] cnt_one = 1;

    sample_t bank0     [p_points];
    sample_t bank1     [p_points];
    sample_t bank0_nxt [p_points];
    sample_t bank1_nxt [p_points];
    sample_t rd_bank   [p_points];
    sample_t a_reg     [p_points];

    logic                 wr_sel, wr_sel_nxt;
    logic                 rd_sel, rd_sel_nxt;
    logic [1:0]           full, full_nxt;
    logic [4:0]           wr_cnt, wr_cnt_nxt;
    logic [4:0]           wr_idx;
    logic [p_cntBits-1:0] frame_cnt, frame_cnt_nxt;
    logic                 frame_valid;
    logic                 accept, consume;

    function automatic logic [4:0] slot_of(input logic [4:0] n);
`ifdef FFT_LOADER_BITREV_EN
        return {n[0], n[1], n[2], n[3], n[4]};
`else
        return n;
`endif
    endfunction

    assign o_ready = ~full[wr_sel];
    // Flush outranks both handshakes, so it masks them here once.
    assign accept  = i_valid & o_ready & ~i_flush;
    assign consume = frame_valid & i_frame_ack & ~i_flush;
    assign wr_idx  = slot_of(wr_cnt);

    // NOTE: every variable gets a default first so always_comb never infers a latch.
    always_comb begin
        full_nxt      = full;
        wr_sel_nxt    = wr_sel;
        rd_sel_nxt    = rd_sel;
        wr_cnt_nxt    = wr_cnt;
        frame_cnt_nxt = frame_cnt;
        if (i_flush) begin
            full_nxt   = '0;
            wr_sel_nxt = 1'b0;
            rd_sel_nxt = 1'b0;
            wr_cnt_nxt = '0;
        end else begin
            if (accept) begin
                wr_cnt_nxt = wr_cnt + 5'd1;
                if (wr_cnt == 5'd31) begin
                    full_nxt[wr_sel] = 1'b1;
                    wr_sel_nxt       = ~wr_sel;
                end
            end
            if (consume) begin
                full_nxt[rd_sel] = 1'b0;
                rd_sel_nxt       = ~rd_sel;
                frame_cnt_nxt    = frame_cnt + cnt_one;
            end
        end
    end

    // Outputs are registered from next-state banks so a frame shows the cycle after its last sample.
    always_comb begin
        bank0_nxt = bank0;
        bank1_nxt = bank1;
        if (accept) begin
            if (wr_sel) bank1_nxt[wr_idx] = i_sample;
            else        bank0_nxt[wr_idx] = i_sample;
        end
        for (int k = 0; k < p_points; k++) begin
            rd_bank[k] = rd_sel_nxt ? bank1_nxt[k] : bank0_nxt[k];
        end
    end

    // NOTE: the banks are cleared on reset because the frame outputs must read zero after reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < p_points; k++) begin
                bank0[k] <= '0;
                bank1[k] <= '0;
                a_reg[k] <= '0;
            end
            full        <= '0;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            wr_cnt      <= '0;
            frame_cnt   <= '0;
            frame_valid <= 1'b0;
        end else begin
            bank0       <= bank0_nxt;
            bank1       <= bank1_nxt;
            a_reg       <= rd_bank;
            full        <= full_nxt;
            wr_sel      <= wr_sel_nxt;
            rd_sel      <= rd_sel_nxt;
            wr_cnt      <= wr_cnt_nxt;
            frame_cnt   <= frame_cnt_nxt;
            frame_valid <= full_nxt[rd_sel_nxt];
        end
    end

    assign o_frame_valid = frame_valid;
    assign o_frame_cnt   = frame_cnt;

    assign o_a0  = a_reg[0];
    assign o_a1  = a_reg[1];
    assign o_a2  = a_reg[2];
    assign o_a3  = a_reg[3];
    assign o_a4  = a_reg[4];
    assign o_a5  = a_reg[5];
    assign o_a6  = a_reg[6];
    assign o_a7  = a_reg[7];
    assign o_a8  = a_reg[8];
    assign o_a9  = a_reg[9];
    assign o_a10 = a_reg[10];
    assign o_a11 = a_reg[11];
    assign o_a12 = a_reg[12];
    assign o_a13 = a_reg[13];
    assign o_a14 = a_reg[14];
    assign o_a15 = a_reg[15];
    assign o_a16 = a_reg[16];
    assign o_a17 = a_reg[17];
    assign o_a18 = a_reg[18];
    assign o_a19 = a_reg[19];
    assign o_a20 = a_reg[20];
    assign o_a21 = a_reg[21];
    assign o_a22 = a_reg[22];
    assign o_a23 = a_reg[23];
    assign o_a24 = a_reg[24];
    assign o_a25 = a_reg[25];
    assign o_a26 = a_reg[26];
    assign o_a27 = a_reg[27];
    assign o_a28 = a_reg[28];
    assign o_a29 = a_reg[29];
    assign o_a30 = a_reg[30];
    assign o_a31 = a_reg[31];

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader; expected slot order follows FFT_LOADER_BITREV_EN.
module tb_fft_input_loader;

    logic              CLK = 1'b0;
    logic              RST;
    logic [8:0]        i_sample;
    logic              i_valid;
    logic              o_ready;
    logic              i_flush;
    logic              o_frame_valid;
    logic              i_frame_ack;
    logic [7:0]        o_frame_cnt;
    logic [31:0][8:0]  a;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    fft_input_loader dut (
        .CLK(CLK), .RST(RST), .i_sample(i_sample), .i_valid(i_valid), .o_ready(o_ready),
        .i_flush(i_flush),
        .o_a0(a[0]),   .o_a1(a[1]),   .o_a2(a[2]),   .o_a3(a[3]),
        .o_a4(a[4]),   .o_a5(a[5]),   .o_a6(a[6]),   .o_a7(a[7]),
        .o_a8(a[8]),   .o_a9(a[9]),   .o_a10(a[10]), .o_a11(a[11]),
        .o_a12(a[12]), .o_a13(a[13]), .o_a14(a[14]), .o_a15(a[15]),
        .o_a16(a[16]), .o_a17(a[17]), .o_a18(a[18]), .o_a19(a[19]),
        .o_a20(a[20]), .o_a21(a[21]), .o_a22(a[22]), .o_a23(a[23]),
        .o_a24(a[24]), .o_a25(a[25]), .o_a26(a[26]), .o_a27(a[27]),
        .o_a28(a[28]), .o_a29(a[29]), .o_a30(a[30]), .o_a31(a[31]),
        .o_frame_valid(o_frame_valid), .i_frame_ack(i_frame_ack), .o_frame_cnt(o_frame_cnt)
    );

    // Output slot holding the sample with time index n.
    function automatic int exp_idx(input int n);
`ifdef FFT_LOADER_BITREV_EN
        logic [4:0] v;
        v = n[4:0];
        return int'({v[0], v[1], v[2], v[3], v[4]});
`else
        return n;
`endif
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_frame_ack = 1'b0; i_sample = '0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic push(input logic [8:0] s);
        int waited = 0;
        i_valid  = 1'b1;
        i_sample = s;
        while (!o_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!o_ready) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout: o_ready stayed %b, required 1", o_ready);
        end
        tick();
        i_valid = 1'b0;
    endtask

    task automatic push_frame(input int base);
        for (int n = 0; n < 32; n++) push(9'(base + n));
    endtask

    task automatic test_reset();
        RST = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_frame_ack = 1'b0; i_sample = '0;
        tick();
        n_checks++;
        if ({o_ready, o_frame_valid, o_frame_cnt} !== {1'b1, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b valid=%b cnt=%0d, required 1 0 0", o_ready, o_frame_valid, o_frame_cnt);
        end
        RST = 1'b0;
        push_frame(0);
        i_frame_ack = 1'b1;
        tick();
        i_frame_ack = 1'b0;
        n_checks++;
        if (o_frame_cnt !== 8'd1) begin
            n_fail++; $display("FAIL reset_pre_cnt: cnt=%0d, required 1", o_frame_cnt);
        end
        for (int n = 0; n < 10; n++) push(9'(50 + n));
        #3 RST = 1'b1;
        #1;
        n_checks++;
        if ({o_ready, o_frame_valid, o_frame_cnt} !== {1'b1, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_async: ready=%b valid=%b cnt=%0d, required 1 0 0", o_ready, o_frame_valid, o_frame_cnt);
        end
        tick();
        RST = 1'b0;
        for (int n = 0; n < 31; n++) push(9'(300 + n));
        n_checks++;
        if (o_frame_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_partial_dropped: valid=%b, required 0", o_frame_valid);
        end
        push(9'd331);
        n_checks++;
        if ({o_frame_valid, a[exp_idx(0)], a[exp_idx(10)], a[exp_idx(31)]} !== {1'b1, 9'd300, 9'd310, 9'd331}) begin
            n_fail++;
            $display("FAIL reset_fresh_frame: valid=%b a0=%0d a10=%0d a31=%0d, required 1 300 310 331",
                     o_frame_valid, a[exp_idx(0)], a[exp_idx(10)], a[exp_idx(31)]);
        end
    endtask

    task automatic test_natural();
        apply_reset();
        for (int n = 0; n < 31; n++) push(9'(n));
        n_checks++;
        if (o_frame_valid !== 1'b0) begin
            n_fail++; $display("FAIL order_early_valid: valid=%b, required 0", o_frame_valid);
        end
        push(9'd31);
        n_checks++;
        if ({o_frame_valid, o_ready} !== 2'b11) begin
            n_fail++; $display("FAIL order_valid: valid=%b ready=%b, required 1 1", o_frame_valid, o_ready);
        end
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (a[exp_idx(k)] !== 9'(k)) begin
                n_fail++; $display("FAIL order_slot%0d: got %0d, required %0d", exp_idx(k), a[exp_idx(k)], k);
            end
        end
        push_frame(32);
        n_checks++;
        if ({o_ready, o_frame_valid, a[exp_idx(7)], o_frame_cnt} !== {1'b0, 1'b1, 9'd7, 8'd0}) begin
            n_fail++;
            $display("FAIL order_second_full: ready=%b valid=%b a7=%0d cnt=%0d, required 0 1 7 0",
                     o_ready, o_frame_valid, a[exp_idx(7)], o_frame_cnt);
        end
    endtask

`ifdef FFT_LOADER_BITREV_EN
    task automatic test_bitrev();
        apply_reset();
        push_frame(0);
        n_checks++;
        if ({a[0], a[1], a[2], a[3], a[31]} !== {9'd0, 9'd16, 9'd8, 9'd24, 9'd31}) begin
            n_fail++;
            $display("FAIL bitrev_slots: a0=%0d a1=%0d a2=%0d a3=%0d a31=%0d, required 0 16 8 24 31",
                     a[0], a[1], a[2], a[3], a[31]);
        end
    endtask
`endif

    task automatic test_back_to_back();
        int frames    = 0;
        bit ready_drop = 1'b0;
        bit data_bad  = 1'b0;
        apply_reset();
        i_frame_ack = 1'b1;
        for (int n = 0; n < 128; n++) begin
            if (!o_ready) ready_drop = 1'b1;
            push(9'(n));
            if (o_frame_valid) begin
                if (a[exp_idx(0)] !== 9'(frames * 32) || a[exp_idx(31)] !== 9'(frames * 32 + 31))
                    data_bad = 1'b1;
                frames++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (o_frame_valid) frames++;
        end
        i_frame_ack = 1'b0;
        n_checks++;
        if (ready_drop !== 1'b0) begin
            n_fail++; $display("FAIL stream_ready: ready dropped=%b, required 0", ready_drop);
        end
        n_checks++;
        if (frames != 4) begin
            n_fail++; $display("FAIL stream_frames: saw %0d valid frames, required 4", frames);
        end
        n_checks++;
        if (data_bad !== 1'b0) begin
            n_fail++; $display("FAIL stream_data: bad frame content=%b, required 0", data_bad);
        end
        n_checks++;
        if (o_frame_cnt !== 8'd4) begin
            n_fail++; $display("FAIL stream_cnt: cnt=%0d, required 4", o_frame_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit ready_seen = 1'b0;
        apply_reset();
        push_frame(0);
        push_frame(32);
        i_valid  = 1'b1;
        i_sample = 9'h1FF;
        for (int i = 0; i < 5; i++) begin
            if (o_ready) ready_seen = 1'b1;
            tick();
        end
        n_checks++;
        if (ready_seen !== 1'b0) begin
            n_fail++; $display("FAIL bp_stall: ready seen=%b, required 0", ready_seen);
        end
        n_checks++;
        if ({o_frame_valid, a[exp_idx(0)], a[exp_idx(31)]} !== {1'b1, 9'd0, 9'd31}) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%b a0=%0d a31=%0d, required 1 0 31", o_frame_valid, a[exp_idx(0)], a[exp_idx(31)]);
        end
        i_frame_ack = 1'b1;
        tick();
        i_frame_ack = 1'b0;
        n_checks++;
        if ({o_frame_valid, o_ready, a[exp_idx(0)], o_frame_cnt} !== {1'b1, 1'b1, 9'd32, 8'd1}) begin
            n_fail++;
            $display("FAIL bp_after_ack: valid=%b ready=%b a0=%0d cnt=%0d, required 1 1 32 1",
                     o_frame_valid, o_ready, a[exp_idx(0)], o_frame_cnt);
        end
        tick();
        i_valid = 1'b0;
        for (int n = 1; n < 32; n++) push(9'(n));
        n_checks++;
        if (o_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_refill: ready=%b, required 0", o_ready);
        end
        i_frame_ack = 1'b1;
        tick();
        i_frame_ack = 1'b0;
        n_checks++;
        if ({o_frame_valid, a[0], a[exp_idx(1)], o_frame_cnt} !== {1'b1, 9'h1FF, 9'd1, 8'd2}) begin
            n_fail++;
            $display("FAIL bp_held_sample: valid=%b a0=%0h a1=%0d cnt=%0d, required 1 1ff 1 2",
                     o_frame_valid, a[0], a[exp_idx(1)], o_frame_cnt);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        push_frame(0);
        i_frame_ack = 1'b1;
        tick();
        i_frame_ack = 1'b0;
        push_frame(100);
        for (int n = 0; n < 17; n++) push(9'(400 + n));
        n_checks++;
        if ({o_frame_valid, a[exp_idx(0)], o_frame_cnt} !== {1'b1, 9'd100, 8'd1}) begin
            n_fail++;
            $display("FAIL flush_setup: valid=%b a0=%0d cnt=%0d, required 1 100 1", o_frame_valid, a[exp_idx(0)], o_frame_cnt);
        end
        i_flush = 1'b1; i_valid = 1'b1; i_sample = 9'h0AA; i_frame_ack = 1'b1;
        tick();
        i_flush = 1'b0; i_valid = 1'b0; i_frame_ack = 1'b0;
        n_checks++;
        if ({o_frame_valid, o_ready, o_frame_cnt} !== {1'b0, 1'b1, 8'd1}) begin
            n_fail++;
            $display("FAIL flush_effect: valid=%b ready=%b cnt=%0d, required 0 1 1", o_frame_valid, o_ready, o_frame_cnt);
        end
        for (int n = 0; n < 31; n++) push(n == 0 ? 9'h100 : (n == 5 ? 9'h1FF : 9'(200 + n)));
        n_checks++;
        if (o_frame_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_wrcnt: valid=%b, required 0", o_frame_valid);
        end
        push(9'd231);
        n_checks++;
        if ({o_frame_valid, o_frame_cnt, a[exp_idx(0)], a[exp_idx(5)], a[exp_idx(31)]}
            !== {1'b1, 8'd1, 9'h100, 9'h1FF, 9'd231}) begin
            n_fail++;
            $display("FAIL flush_new_frame: valid=%b cnt=%0d a0=%0h a5=%0h a31=%0d, required 1 1 100 1ff 231",
                     o_frame_valid, o_frame_cnt, a[exp_idx(0)], a[exp_idx(5)], a[exp_idx(31)]);
        end
    endtask

    initial begin
        test_reset();
        test_natural();
`ifdef FFT_LOADER_BITREV_EN
        test_bitrev();
`endif
        test_back_to_back();
        test_backpressure();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
